// File: rtl/led_pwm_fader_if.sv
// Request/LED bundle for the RGB PWM fader: per-channel fade targets in,
// active-low LED pins and the fading flag out.
interface led_pwm_fader_if;
  logic req_r;
  logic req_g;
  logic req_b;
  logic LED_R;
  logic LED_G;
  logic LED_B;
  logic fading;

  modport master (
    output req_r, req_g, req_b,
    input  LED_R, LED_G, LED_B, fading
  );

  modport slave (
    input  req_r, req_g, req_b,
    output LED_R, LED_G, LED_B, fading
  );
endinterface

// File: rtl/led_pwm_fader.sv
// Three-channel LED fader: a free-running PWM counter drives each channel from
// a per-period shadow duty, while duty ramps one step every FADE_DIV periods.
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  led_pwm_fader_if.slave  bus
);
  localparam logic [PWM_BITS-1:0] DMAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] DONE  = PWM_BITS'(1);
  localparam int                  SW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(FADE_DIV - 1);
  localparam logic [SW-1:0]       STEP_ONE  = SW'(1);
  localparam logic [SW-1:0]       STEP_ZERO = {SW{1'b0}};

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [SW-1:0]       step_cnt_r;
  logic [PWM_BITS-1:0] duty_r     [3];
  logic [PWM_BITS-1:0] duty_act_r [3];
  logic [PWM_BITS-1:0] duty_nxt_s [3];
  logic [2:0]          req_s;
  logic [2:0]          lit_s;
  logic [2:0]          busy_s;
  logic                period_end_s;
  logic                step_s;

  // Full scale must light every cycle, which pwm_cnt < DMAX alone would miss.
  function automatic logic lit_f(input logic [PWM_BITS-1:0] cnt,
                                 input logic [PWM_BITS-1:0] act);
    logic res;
    if (act == DZERO) begin
      res = 1'b0;
    end else if (act == DMAX) begin
      res = 1'b1;
    end else begin
      res = (cnt < act);
    end
    return res;
  endfunction

  assign req_s        = {bus.req_b, bus.req_g, bus.req_r};
  assign period_end_s = (pwm_cnt_r == DMAX);
  assign step_s       = period_end_s && (step_cnt_r == STEP_LAST);

  // Per-channel next duty, lit decision and ramp-in-progress flag.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      duty_nxt_s[i] = duty_r[i];
      if (step_s && req_s[i] && (duty_r[i] != DMAX)) begin
        duty_nxt_s[i] = duty_r[i] + DONE;
      end else if (step_s && !req_s[i] && (duty_r[i] != DZERO)) begin
        duty_nxt_s[i] = duty_r[i] - DONE;
      end else begin
        duty_nxt_s[i] = duty_r[i];
      end
      busy_s[i] = req_s[i] ? (duty_r[i] != DMAX) : (duty_r[i] != DZERO);
      lit_s[i]  = lit_f(pwm_cnt_r, duty_act_r[i]);
    end
  end

  // PWM period counter and fade-step prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r  <= DZERO;
      step_cnt_r <= STEP_ZERO;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + DONE;
      if (period_end_s) begin
        step_cnt_r <= (step_cnt_r == STEP_LAST) ? STEP_ZERO : step_cnt_r + STEP_ONE;
      end else begin
        step_cnt_r <= step_cnt_r;
      end
    end
  end

  // Duty registers; the shadow copy loads at period end so a period never mixes levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        duty_r[i]     <= DZERO;
        duty_act_r[i] <= DZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        duty_r[i] <= duty_nxt_s[i];
        if (period_end_s) begin
          duty_act_r[i] <= duty_nxt_s[i];
        end else begin
          duty_act_r[i] <= duty_act_r[i];
        end
      end
    end
  end

  // Registered active-low pins and fading flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.LED_R  <= 1'b1;
      bus.LED_G  <= 1'b1;
      bus.LED_B  <= 1'b1;
      bus.fading <= 1'b0;
    end else begin
      bus.LED_R  <= ~lit_s[0];
      bus.LED_G  <= ~lit_s[1];
      bus.LED_B  <= ~lit_s[2];
      bus.fading <= |busy_s;
    end
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=3, FADE_DIV=2 (8-cycle period,
// fade step every 16 cycles); edge n is the n-th rising edge after reset release.
module tb_led_pwm_fader;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  led_pwm_fader_if bus_if ();

  led_pwm_fader #(.PWM_BITS(3), .FADE_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Duty after edge e when req is 1 on edges on_e..off_e; steps land on multiples of 16.
  function automatic int duty_at(int e, int on_e, int off_e);
    int d = 0;
    for (int s = 16; s <= e; s += 16) begin
      if (s >= on_e && s <= off_e) begin
        if (d < 7) d++;
      end else if (d > 0) begin
        d--;
      end
    end
    return d;
  endfunction

  function automatic logic led_exp(int n, int on_e, int off_e);
    int p = (n - 1) % 8;
    int d = duty_at(n - 1, on_e, off_e);
    logic lit = (d == 0) ? 1'b0 : (d == 7) ? 1'b1 : (p < d);
    return ~lit;
  endfunction

  function automatic logic fading_exp(int n, int on_e, int off_e);
    int d = duty_at(n - 1, on_e, off_e);
    logic r = (n >= on_e && n <= off_e);
    return r ? (d < 7) : (d > 0);
  endfunction

  task automatic release_with(input logic r, input logic g, input logic b);
    rst_n = 1'b0;
    bus_if.req_r = r;
    bus_if.req_g = g;
    bus_if.req_b = b;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_if.req_r = 1'b0;
    bus_if.req_g = 1'b0;
    bus_if.req_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus_if.LED_R, bus_if.LED_G, bus_if.LED_B, bus_if.fading} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_state got %b want 1110",
               {bus_if.LED_R, bus_if.LED_G, bus_if.LED_B, bus_if.fading});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus_if.LED_R, bus_if.LED_G, bus_if.LED_B, bus_if.fading} !== 4'b1110) begin
        n_err++;
        $display("FAIL idle_dark n=%0d got %b want 1110", n,
                 {bus_if.LED_R, bus_if.LED_G, bus_if.LED_B, bus_if.fading});
      end
    end
  endtask

  task automatic test_ramp_up;
    int lit_cnt = 0;
    int d;
    int want_cnt;
    release_with(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.LED_G !== led_exp(n, 1, NEVER)) begin
        n_err++;
        $display("FAIL ramp_led_g n=%0d got %b want %b", n, bus_if.LED_G, led_exp(n, 1, NEVER));
      end
      n_cmp++;
      if ({bus_if.LED_R, bus_if.LED_B} !== 2'b11) begin
        n_err++;
        $display("FAIL ramp_rb_dark n=%0d got %b want 11", n, {bus_if.LED_R, bus_if.LED_B});
      end
      n_cmp++;
      if (bus_if.fading !== fading_exp(n, 1, NEVER)) begin
        n_err++;
        $display("FAIL ramp_fading n=%0d got %b want %b", n, bus_if.fading, fading_exp(n, 1, NEVER));
      end
      if (bus_if.LED_G === 1'b0) lit_cnt++;
      if (n % 8 == 0) begin
        d = duty_at(n - 8, 1, NEVER);
        want_cnt = (d == 7) ? 8 : d;
        n_cmp++;
        if (lit_cnt != want_cnt) begin
          n_err++;
          $display("FAIL ramp_period_lit n=%0d got %0d want %0d", n, lit_cnt, want_cnt);
        end
        lit_cnt = 0;
      end
    end
  endtask

  task automatic test_reversal;
    release_with(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 150; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.LED_G !== led_exp(n, 1, 70)) begin
        n_err++;
        $display("FAIL rev_led_g n=%0d got %b want %b", n, bus_if.LED_G, led_exp(n, 1, 70));
      end
      n_cmp++;
      if (bus_if.fading !== fading_exp(n, 1, 70)) begin
        n_err++;
        $display("FAIL rev_fading n=%0d got %b want %b", n, bus_if.fading, fading_exp(n, 1, 70));
      end
      if (n == 70) bus_if.req_g = 1'b0;
    end
  endtask

  task automatic test_simultaneous;
    release_with(1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.LED_R !== led_exp(n, 6, NEVER)) begin
        n_err++;
        $display("FAIL sim_led_r n=%0d got %b want %b", n, bus_if.LED_R, led_exp(n, 6, NEVER));
      end
      n_cmp++;
      if (bus_if.LED_B !== bus_if.LED_R) begin
        n_err++;
        $display("FAIL sim_b_eq_r n=%0d got %b want %b", n, bus_if.LED_B, bus_if.LED_R);
      end
      n_cmp++;
      if (bus_if.LED_G !== 1'b1) begin
        n_err++;
        $display("FAIL sim_g_dark n=%0d got %b want 1", n, bus_if.LED_G);
      end
      n_cmp++;
      if (bus_if.fading !== fading_exp(n, 6, NEVER)) begin
        n_err++;
        $display("FAIL sim_fading n=%0d got %b want %b", n, bus_if.fading, fading_exp(n, 6, NEVER));
      end
      if (n == 5) begin
        bus_if.req_r = 1'b1;
        bus_if.req_b = 1'b1;
      end
    end
  endtask

  task automatic test_mid_reset;
    release_with(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 57; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus_if.LED_G, bus_if.fading} !== {led_exp(n, 1, NEVER), fading_exp(n, 1, NEVER)}) begin
        n_err++;
        $display("FAIL pre_rst n=%0d got %b want %b", n, {bus_if.LED_G, bus_if.fading},
                 {led_exp(n, 1, NEVER), fading_exp(n, 1, NEVER)});
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.LED_R, bus_if.LED_G, bus_if.LED_B, bus_if.fading} !== 4'b1110) begin
      n_err++;
      $display("FAIL async_rst got %b want 1110",
               {bus_if.LED_R, bus_if.LED_G, bus_if.LED_B, bus_if.fading});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus_if.LED_G, bus_if.fading} !== {led_exp(n, 1, NEVER), fading_exp(n, 1, NEVER)}) begin
        n_err++;
        $display("FAIL post_rst n=%0d got %b want %b", n, {bus_if.LED_G, bus_if.fading},
                 {led_exp(n, 1, NEVER), fading_exp(n, 1, NEVER)});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.req_r = 1'b0;
    bus_if.req_g = 1'b0;
    bus_if.req_b = 1'b0;
    test_reset();
    test_ramp_up();
    test_reversal();
    test_simultaneous();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
